// File: rtl/avg_pkg.sv
// Shared types and helpers for the multi-channel moving-average block.
package avg_pkg;

  // Widest channel index the pipeline stage carries (NCH is at most 16).
  localparam int unsigned MAX_CH_W   = 4;
  // Widest sample the pipeline stage carries; DATA_W must not exceed this.
  localparam int unsigned MAX_DATA_W = 32;

  // Channel index width: max(1, clog2(nch)).
  function automatic int unsigned ch_width(input int unsigned nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

  // One accepted sample travelling from the RAM-access stage to the sum stage.
  typedef struct packed {
    logic                  valid;
    logic [MAX_CH_W-1:0]   ch;
    logic [MAX_DATA_W-1:0] din;
    logic                  full;
  } stage_t;

endpackage

// File: rtl/avg_ram.sv
// Simple dual-port RAM, read-first, one cycle read latency, no reset.
module avg_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [1 << ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Read returns the pre-write contents when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avg_window_mc.sv
// Per-channel moving average over a 2^pow sample window, one sample per cycle,
// two-cycle latency. Stage 0 reads/writes the sample RAM and advances pointer and
// fill; stage 1 folds the new and oldest sample into the running sum.
module avg_window_mc
  import avg_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NCH     = 4,
  parameter int unsigned MAX_POW = 8,
  parameter int unsigned FRAC_W  = 8,
  localparam int unsigned CH_W   = ch_width(NCH),
  localparam int unsigned POW_W  = $clog2(MAX_POW + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [DATA_W-1:0]        din,
  input  logic [POW_W-1:0]         win_pow,
  input  logic                     clear,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W+FRAC_W-1:0] q,
  output logic                     out_full
);

  localparam int unsigned PTR_W  = MAX_POW;
  localparam int unsigned FILL_W = MAX_POW + 1;
  localparam int unsigned SUM_W  = DATA_W + MAX_POW;
  localparam int unsigned Q_W    = DATA_W + FRAC_W;
  localparam int unsigned ADDR_W = CH_W + PTR_W;

  localparam logic [CH_W:0]      NCH_L     = (CH_W + 1)'(NCH);
  localparam logic [POW_W-1:0]   MAX_POW_L = POW_W'(MAX_POW);

  logic [POW_W-1:0]  pow_q, pow_d;
  logic [PTR_W-1:0]  wptr_q [NCH];
  logic [FILL_W-1:0] fill_q [NCH];
  logic [SUM_W-1:0]  sum_q  [NCH];
  stage_t            stage_q, stage_d;

  logic              accept;
  logic [FILL_W-1:0] n_win;
  logic [PTR_W-1:0]  cur_wptr;
  logic [FILL_W-1:0] cur_fill;
  logic              cur_full;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] old_data;

  logic [CH_W-1:0]         s1_ch;
  logic [SUM_W-1:0]        sum_new;
  logic [SUM_W+FRAC_W-1:0] q_wide;

  logic            out_valid_q;
  logic [CH_W-1:0] out_ch_q;
  logic [Q_W-1:0]  q_q;
  logic            out_full_q;

  // Window exponent requested on clear, clamped to the buffer depth.
  always_comb begin
    pow_d = (win_pow > MAX_POW_L) ? MAX_POW_L : win_pow;
  end

  // Stage 0: accept decision, window size and RAM addressing for the incoming sample.
  always_comb begin
    accept   = in_valid && ({1'b0, in_ch} < NCH_L) && !clear && !reset;
    n_win    = FILL_W'(1) << pow_q;
    cur_wptr = wptr_q[in_ch];
    cur_fill = fill_q[in_ch];
    cur_full = (cur_fill == n_win);
    waddr    = {in_ch, cur_wptr};
    // N = depth wraps to the write slot itself; the read-first RAM returns the old sample.
    raddr    = {in_ch, cur_wptr - n_win[PTR_W-1:0]};
  end

  // Latched window exponent: full depth out of reset, requested value on clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pow_q <= MAX_POW_L;
    end else if (clear) begin
      pow_q <= pow_d;
    end
  end

  // Write pointer and saturating fill counter, advanced as soon as a sample is accepted.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        wptr_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else if (accept) begin
      wptr_q[in_ch] <= cur_wptr + PTR_W'(1);
      if (!cur_full) begin
        fill_q[in_ch] <= cur_fill + FILL_W'(1);
      end
    end
  end

  avg_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (waddr),
    .wdata_i (din),
    .raddr_i (raddr),
    .rdata_o (old_data)
  );

  // Carry the accepted sample alongside its RAM read into stage 1.
  always_comb begin
    stage_d       = '0;
    stage_d.valid = accept;
    stage_d.ch    = MAX_CH_W'(in_ch);
    stage_d.din   = MAX_DATA_W'(din);
    stage_d.full  = cur_full;
  end

  // Stage register; reset drops whatever is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Stage 1: new running sum and the scaled average derived from it.
  always_comb begin
    s1_ch   = stage_q.ch[CH_W-1:0];
    sum_new = sum_q[s1_ch] + SUM_W'(stage_q.din[DATA_W-1:0])
              - (stage_q.full ? SUM_W'(old_data) : '0);
    q_wide  = {sum_new, {FRAC_W{1'b0}}} >> pow_q;
  end

  // Running sums; only stage 1 writes them, so same-channel back-to-back samples chain.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        sum_q[i] <= '0;
      end
    end else if (stage_q.valid) begin
      sum_q[s1_ch] <= sum_new;
    end
  end

  // Result registers; a clear kills the sample in stage 1, data holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      q_q         <= '0;
      out_full_q  <= 1'b0;
    end else begin
      out_valid_q <= stage_q.valid && !clear;
      if (stage_q.valid && !clear) begin
        out_ch_q   <= s1_ch;
        q_q        <= q_wide[Q_W-1:0];
        out_full_q <= stage_q.full;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign q         = q_q;
  assign out_full  = out_full_q;

  // Stage fields are sized for the widest configuration; the spare bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{stage_q.ch, stage_q.din, q_wide};

endmodule

// File: tb/tb_avg_window_mc.sv
// Scoreboard bench for avg_window_mc: the driver predicts each result from a
// per-channel sample history and queues it with its due cycle; a negedge monitor
// pops and compares whenever the DUT presents out_valid.
module tb_avg_window_mc;

  // NCH = 3 leaves index 3 representable on in_ch, so out-of-range samples can be driven.
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NCH     = 3;
  localparam int unsigned MAX_POW = 8;
  localparam int unsigned FRAC_W  = 8;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned POW_W   = 4;

  logic                     clk = 1'b0;
  logic                     reset, in_valid, clear;
  logic [CH_W-1:0]          in_ch;
  logic [DATA_W-1:0]        din;
  logic [POW_W-1:0]         win_pow;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic [DATA_W+FRAC_W-1:0] q;
  logic                     out_full;

  avg_window_mc #(
    .DATA_W  (DATA_W),
    .NCH     (NCH),
    .MAX_POW (MAX_POW),
    .FRAC_W  (FRAC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .din       (din),
    .win_pow   (win_pow),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .q         (q),
    .out_full  (out_full)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int cyc;
    int ch;
    int qv;
    int full;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   hist[NCH][$];
  int   pow_m   = MAX_POW;
  int   cyc     = 0;
  int   rst_cyc = -10;
  int   checks  = 0;
  int   errors  = 0;
  bit   mon_en  = 1'b0;
  bit   have_last = 1'b0;
  int   last_q, last_ch;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void model_reset(input int p);
    pow_m = p;
    for (int i = 0; i < NCH; i++) hist[i].delete();
  endfunction

  // Results due after cycle c belong to samples a clear/reset in cycle c destroys.
  function automatic void flush_after(input int c);
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > c) exp_q.delete(exp_q.size()-1);
  endfunction

  // Present one sample this cycle; qlit/flit override the model with literal values.
  task automatic issue(input int ch, input int d, input int qlit = -1, input int flit = -1);
    int   n, sum;
    exp_t e;
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    din      = DATA_W'(d);
    win_pow  = POW_W'($urandom_range(0, 15));
    if (ch < NCH) begin
      n      = 1 << pow_m;
      e.full = (hist[ch].size() == n) ? 1 : 0;
      hist[ch].push_back(d);
      if (hist[ch].size() > n) void'(hist[ch].pop_front());
      sum = 0;
      for (int i = 0; i < hist[ch].size(); i++) sum += hist[ch][i];
      e.cyc = cyc + 2;
      e.ch  = ch;
      e.qv  = ((sum << FRAC_W) >> pow_m) & 32'hFFFF;
      if (qlit >= 0) e.qv = qlit;
      if (flit >= 0) e.full = flit;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear(input int wp, input bit v, input int ch, input int d);
    reset    = 1'b0;
    clear    = 1'b1;
    win_pow  = POW_W'(wp);
    in_valid = v;
    in_ch    = CH_W'(ch);
    din      = DATA_W'(d);
    model_reset((wp > MAX_POW) ? MAX_POW : wp);
    flush_after(cyc);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Reset wins over a simultaneous clear (win_pow 0) and sample.
  task automatic do_reset();
    reset    = 1'b1;
    clear    = 1'b1;
    win_pow  = '0;
    in_valid = 1'b1;
    in_ch    = '0;
    din      = 8'd9;
    rst_cyc  = cyc;
    model_reset(MAX_POW);
    flush_after(cyc);
    @(negedge clk);
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_full", out_full, 0);
  endtask

  // Monitor: every out_valid must match the head of the queue in its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == rst_cyc + 1) begin
        last_q    = 0;
        last_ch   = 0;
        have_last = 1'b1;
      end
      if (out_valid) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: out_valid=1 ch=%0d q=0x%0h at cycle %0d, required none",
                   out_ch, q, cyc);
          if (exp_q.size() > 0 && exp_q[0].cyc < cyc) exp_q.delete(0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_ch", out_ch, mon_e.ch);
          check("q", q, mon_e.qv);
          check("out_full", out_full, mon_e.full);
          last_q    = q;
          last_ch   = out_ch;
          have_last = 1'b1;
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_out: out_valid=0 at cycle %0d, required ch=%0d q=0x%0h",
                 cyc, exp_q[0].ch, exp_q[0].qv);
        exp_q.delete(0);
      end else if (have_last) begin
        check("hold_q", q, last_q);
        check("hold_ch", out_ch, last_ch);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_ch    = '0;
    din      = '0;
    win_pow  = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    do_reset();

    // Constant 100 on ch0, N = 4: ramps up, then saturates with full set.
    do_clear(2, 1'b0, 0, 0);
    issue(0, 100, 'h1900, 0);
    issue(0, 100, 'h3200, 0);
    issue(0, 100, 'h4B00, 0);
    issue(0, 100, 'h6400, 0);
    issue(0, 100, 'h6400, 1);
    idle(3);

    // Step response: 0xFF x4 then 0x00 x4.
    do_clear(2, 1'b0, 0, 0);
    issue(0, 'hFF, 'h3FC0, 0);
    issue(0, 'hFF, 'h7F80, 0);
    issue(0, 'hFF, 'hBF40, 0);
    issue(0, 'hFF, 'hFF00, 0);
    issue(0, 0, 'hBF40, 1);
    issue(0, 0, 'h7F80, 1);
    issue(0, 0, 'h3FC0, 1);
    issue(0, 0, 'h0000, 1);
    idle(3);

    // Interleaved channels every cycle, N = 2.
    do_clear(1, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        issue(0, 10);
        issue(1, 200);
      end else begin
        issue(0, 10, 'h0A00);
        issue(1, 200, 'hC800);
      end
    end
    idle(3);

    // Full-depth window: read-first RAM must return the oldest sample.
    do_clear(8, 1'b0, 0, 0);
    repeat (256) issue(2, 1);
    issue(2, 3, 'h0102, 1);
    idle(3);

    // Clear with a sample presented and two in flight.
    do_clear(3, 1'b0, 0, 0);
    issue(0, 20);
    issue(0, 30);
    do_clear(3, 1'b1, 0, 77);
    for (int k = 0; k < 3; k++) begin
      check("clear_quiet", out_valid, 0);
      idle(1);
    end
    issue(0, 50, 'h3200 >> 3, 0);
    idle(3);

    // Out-of-range channel is dropped; win_pow 15 clamps to MAX_POW.
    do_clear(15, 1'b0, 0, 0);
    issue(0, 100, 'h0064, 0);
    issue(3, 77);
    issue(3, 99);
    issue(0, 100, 'h00C8, 0);
    issue(1, 5, 'h0005, 0);
    idle(3);

    // Randomized mix with occasional clears and one mid-stream reset.
    do_clear($urandom_range(0, 3), 1'b0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (k == 300) begin
        do_reset();
      end else if (r < 2) begin
        do_clear($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 255));
      end else if (r < 80) begin
        issue($urandom_range(0, 3), $urandom_range(0, 255));
      end else begin
        idle(1);
      end
    end

    idle(5);
    check("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
